logic_unit_arbiter: RTL
=======================

Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT) between NREQ requesters.
- Each requester submits operands a, b and a 3-bit opcode over a valid/ready handshake. A round-robin arbiter grants one requester at a time.
- A 3-state FSM sequences accept, execute and respond. Results return on a single response channel tagged with the requester id.
- Sits between multiple datapath clients and the team's gate-level logic function.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits (1..32).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept strobe.
- req_a  input  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b, same packing.
- req_op  input  NREQ*3  opcode, [i*3 +: 3].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer ready.
- rsp_data  output  WIDTH  result.
- rsp_id  output  IDW  index of requester that owns the result.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, busy=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - Deasserting rst_n mid-operation discards any in-flight request; that request is not re-issued.
- Opcodes:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR: bitwise, all WIDTH bits.
  - 6 NOT a, 7 NOT b.
- IDLE:
  - Grant is combinational: search req_valid starting at index rr_ptr, ascending with wrap; the first set bit wins.
  - req_ready[winner]=1 in the same cycle; all other req_ready bits=0. A transfer occurs when req_valid & req_ready are both high.
  - On a transfer, latch a, b, op and id, then go to EXEC.
  - No valid request: stay in IDLE, req_ready=0.
- EXEC:
  - Compute op(a,b) into the rsp_data register.
  - Load rsp_id, set rsp_valid=1, go to RESP.
  - req_ready=0.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready cycle: clear rsp_valid, set rr_ptr=(id+1) mod NREQ, go to IDLE.
  - req_ready=0 throughout RESP.
- Latency:
  - Accept in cycle t, rsp_valid high at t+2.
  - Back-to-back throughput: one op per 3 cycles when rsp_ready is held high.
- Protocol rules:
  - Requesters hold req_valid and operands stable until accepted.
  - The block never accepts a new request while a response is pending; there is no buffering beyond one op.
  - rsp_ready high while rsp_valid=0 has no effect.
- Fairness:
  - A requester that is continuously valid is granted within NREQ grants.
  - rr_ptr changes only on response completion.
- Boundaries:
  - Winner at index NREQ-1 wraps rr_ptr to 0.
  - Single active requester: granted every round.

Optional Feature:
- Macro LOGIC_ARB_STATS_EN.
- Defined:
  - Adds output op_count (16 bits): a count of completed responses, incremented on each rsp_valid & rsp_ready cycle.
  - Saturates at 16'hFFFF; reset to 0 by rst_n.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, NREQ=4, WIDTH=8: rst_n low with random inputs -> all outputs 0 and busy=0; release, no req_valid -> req_ready stays 0.
- Single op: requester 2 sends a=8'hF0, b=8'h3C, op=4 (XOR), rsp_ready=1 -> req_ready[2] pulses at t, rsp_valid at t+2 with rsp_data=8'hCC, rsp_id=2, then IDLE.
- Opcode sweep: a=8'hA5, b=8'h0F, ops 0..7 -> 05, AF, FA, 50, AA, 55, 5A, F0.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 with one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, no req_ready pulses, busy=1; raise rsp_ready -> completes next cycle.
- Reset mid-operation: rst_n pulsed low during EXEC -> outputs 0 immediately, rr_ptr=0, and the in-flight result is never presented. With LOGIC_ARB_STATS_EN: 3 completions -> op_count=3; reset -> op_count=0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin share of one bitwise logic unit among NREQ valid/ready requesters.
// Define LOGIC_ARB_STATS_EN to add a saturating op_count of completed responses.
module logic_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
`ifdef LOGIC_ARB_STATS_EN
    output logic [15:0]           op_count,
`endif
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;
    logic [IDW-1:0] rr_ptr, id_q, grant_id;
    logic grant_vld;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0] rot;
    logic [IDW:0] sum;
    logic [WIDTH-1:0] a_q, b_q, result;
    logic [2:0] op_q;
    // Rotate so bit 0 is rr_ptr; the lowest set bit of rot is the winner.
    always_comb begin
        dbl = {req_valid, req_valid} >> rr_ptr;
        rot = dbl[NREQ-1:0];
        grant_vld = 1'b0;
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_vld = 1'b1;
                sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            end
        end
        grant_id = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
    end
    assign req_ready = (rst_n && state == IDLE && grant_vld) ? (NREQ'(1) << grant_id) : '0;
    assign busy = (state != IDLE);
    always_comb begin
        case (op_q)
            3'd0:    result = a_q & b_q;
            3'd1:    result = a_q | b_q;
            3'd2:    result = ~(a_q & b_q);
            3'd3:    result = ~(a_q | b_q);
            3'd4:    result = a_q ^ b_q;
            3'd5:    result = ~(a_q ^ b_q);
            3'd6:    result = ~a_q;
            default: result = ~b_q;
        endcase
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_vld ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (state == IDLE && grant_vld) begin
                a_q  <= req_a[grant_id*WIDTH +: WIDTH];
                b_q  <= req_b[grant_id*WIDTH +: WIDTH];
                op_q <= req_op[grant_id*3 +: 3];
                id_q <= grant_id;
            end
            if (state == EXEC) begin
                rsp_data  <= result;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end
`ifdef LOGIC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                 op_count <= '0;
        else if (state == RESP && rsp_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
`endif
endmodule
